// File: rtl/sram_like_mem_port.sv
// Core-side enable/stall memory port bridged onto two independent sram-like channels.
// Each channel issues one request at a time and holds returned data until the pipeline releases.

module sram_like_chan (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_longest_stall,
   input  logic        i_en,
   input  logic        i_addr_ok,
   input  logic        i_data_ok,
   input  logic [31:0] i_rdata,
   output logic        o_req,
   output logic        o_stall,
   output logic [31:0] o_hold
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_cancel;
   logic        w_cancel_next;
   logic [31:0] r_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cancel <= 1'b0;
         r_hold   <= '0;
      end else begin
         r_state  <= w_state_next;
         r_cancel <= w_cancel_next;
         if (r_state == WAIT && i_data_ok)
            r_hold <= i_rdata;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cancel_next = r_cancel;
      o_req         = 1'b0;
      case (r_state)
         IDLE, REQ: begin
            // IDLE with en behaves as REQ in the same cycle; req is masked while in reset
            o_req = i_en & ~rst;
            if (!i_en)
               w_state_next = IDLE;
            else if (i_addr_ok)
               w_state_next = WAIT;
            else
               w_state_next = REQ;
         end
         WAIT: begin
            if (i_data_ok) begin
               w_cancel_next = 1'b0;
               if (i_en && !r_cancel)
                  w_state_next = DONE;
               else
                  w_state_next = IDLE;
            end else if (!i_en) begin
               w_cancel_next = 1'b1;
            end
         end
         DONE: begin
            if (!i_longest_stall)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // A flushed transaction keeps the core stalled until its response drains
   assign o_stall = (i_en & (r_state != DONE)) | r_cancel;
   assign o_hold  = r_hold;
endmodule

module sram_like_mem_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        longest_stall,
   input  logic        inst_en,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        instrStall,
   input  logic        data_en,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        dataStall,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_wdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata_i,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata_i
);
   logic [1:0]  w_en;
   logic [1:0]  w_addr_ok;
   logic [1:0]  w_data_ok;
   logic [1:0]  w_req;
   logic [1:0]  w_stall;
   logic [31:0] w_rdata_i [2];
   logic [31:0] w_hold [2];
   logic [1:0]  w_data_size;

   assign w_en         = {data_en, inst_en};
   assign w_addr_ok    = {data_addr_ok, inst_addr_ok};
   assign w_data_ok    = {data_data_ok, inst_data_ok};
   assign w_rdata_i[0] = inst_rdata_i;
   assign w_rdata_i[1] = data_rdata_i;

   // Index 0 is the fetch channel, index 1 the load/store channel
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         sram_like_chan u_chan (
            .clk             (clk),
            .rst             (rst),
            .i_longest_stall (longest_stall),
            .i_en            (w_en[gi]),
            .i_addr_ok       (w_addr_ok[gi]),
            .i_data_ok       (w_data_ok[gi]),
            .i_rdata         (w_rdata_i[gi]),
            .o_req           (w_req[gi]),
            .o_stall         (w_stall[gi]),
            .o_hold          (w_hold[gi])
         );
      end
   endgenerate

   // Reads fetch a full word; the core extracts bytes itself
   always_comb begin
      w_data_size = 2'd2;
      case (data_wen)
         4'b0011, 4'b1100:                   w_data_size = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: w_data_size = 2'd0;
         default:                            w_data_size = 2'd2;
      endcase
   end

   assign inst_req     = w_req[0];
   assign instrStall   = w_stall[0];
   assign inst_rdata   = w_hold[0];
   assign inst_wr      = 1'b0;
   assign inst_size    = 2'd2;
   assign inst_addr_o  = inst_addr;
   assign inst_wdata   = '0;

   assign data_req     = w_req[1];
   assign dataStall    = w_stall[1];
   assign data_rdata   = w_hold[1];
   assign data_wr      = |data_wen;
   assign data_size    = w_data_size;
   assign data_addr_o  = data_addr;
   assign data_wdata_o = data_wdata;
endmodule

// File: tb/tb_sram_like_mem_port.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.

module tb_sram_like_mem_port;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, longest_stall;
   logic        inst_en, data_en;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [3:0]  data_wen;
   logic [31:0] inst_rdata, data_rdata;
   logic        instrStall, dataStall;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr_o, inst_wdata, data_addr_o, data_wdata_o;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata_i, data_rdata_i;

   sram_like_mem_port dut (
      .clk(clk), .rst(rst), .longest_stall(longest_stall),
      .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .instrStall(instrStall),
      .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .dataStall(dataStall),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr_o(inst_addr_o),
      .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata_i(inst_rdata_i),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr_o(data_addr_o),
      .data_wdata_o(data_wdata_o), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata_i(data_rdata_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: per channel, is a transaction in flight, was it flushed,
   // is its result being presented, and what was the last returned word.
   bit          m_issued    [2] = '{0, 0};
   bit          m_flushed   [2] = '{0, 0};
   bit          m_delivered [2] = '{0, 0};
   logic [31:0] m_hold      [2] = '{32'h0, 32'h0};

   function automatic logic ch_en(input int ch);
      return (ch == 0) ? inst_en : data_en;
   endfunction

   function automatic logic exp_req(input int ch);
      return !rst && ch_en(ch) && !m_issued[ch] && !m_delivered[ch];
   endfunction

   function automatic logic exp_stall(input int ch);
      return (ch_en(ch) && !m_delivered[ch]) || m_flushed[ch];
   endfunction

   function automatic logic [1:0] exp_size(input logic [3:0] wen);
      if (wen == 4'b0000)          return 2'd2;
      if ($countones(wen) == 1)    return 2'd0;
      if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
      return 2'd2;
   endfunction

   always @(posedge clk) begin
      logic en, aok, dok;
      logic [31:0] rd;
      for (int ch = 0; ch < 2; ch++) begin
         en  = ch_en(ch);
         aok = (ch == 0) ? inst_addr_ok : data_addr_ok;
         dok = (ch == 0) ? inst_data_ok : data_data_ok;
         rd  = (ch == 0) ? inst_rdata_i : data_rdata_i;
         if (rst) begin
            m_issued[ch] = 0; m_flushed[ch] = 0; m_delivered[ch] = 0; m_hold[ch] = '0;
         end else if (m_delivered[ch]) begin
            if (!longest_stall) m_delivered[ch] = 0;
         end else if (m_issued[ch]) begin
            if (dok) begin
               m_hold[ch]      = rd;
               m_delivered[ch] = en && !m_flushed[ch];
               m_issued[ch]    = 0;
               m_flushed[ch]   = 0;
               $display("txn ch=%0d rdata=%h %s", ch, rd, m_delivered[ch] ? "delivered" : "discarded");
            end else if (!en) begin
               m_flushed[ch] = 1;
            end
         end else if (en && aok) begin
            m_issued[ch] = 1;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      chk("inst_req",   inst_req,   exp_req(0));
      chk("instrStall", instrStall, exp_stall(0));
      chk("inst_rdata", inst_rdata, m_hold[0]);
      chk("data_req",   data_req,   exp_req(1));
      chk("dataStall",  dataStall,  exp_stall(1));
      chk("data_rdata", data_rdata, m_hold[1]);
      if (exp_req(0)) begin
         chk("inst_addr_o", inst_addr_o, inst_addr);
         chk("inst_wr",     inst_wr,     0);
         chk("inst_size",   inst_size,   2);
         chk("inst_wdata",  inst_wdata,  0);
      end
      if (exp_req(1)) begin
         chk("data_addr_o",  data_addr_o,  data_addr);
         chk("data_wr",      data_wr,      |data_wen);
         chk("data_size",    data_size,    exp_size(data_wen));
         chk("data_wdata_o", data_wdata_o, data_wdata);
      end
   end

   task automatic quiet(input int n);
      repeat (n) begin
         @(negedge clk);
         inst_en = 0; data_en = 0; data_wen = 0; longest_stall = 0;
         inst_addr_ok = 0; inst_data_ok = 0; data_addr_ok = 0; data_data_ok = 0;
      end
   endtask

   logic [3:0] wen_tab [9] = '{4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

   initial begin
      rst = 1; longest_stall = 0; inst_en = 1; data_en = 1; data_wen = 0;
      inst_addr = 0; data_addr = 0; data_wdata = 0;
      inst_addr_ok = 0; inst_data_ok = 0; data_addr_ok = 0; data_data_ok = 0;
      inst_rdata_i = 0; data_rdata_i = 0;

      @(negedge clk); #2;
      chk("rst_inst_req", inst_req, 0);
      chk("rst_data_req", data_req, 0);
      chk("rst_instrStall", instrStall, 1);
      chk("rst_dataStall", dataStall, 1);
      chk("rst_inst_rdata", inst_rdata, 0);
      @(negedge clk); rst = 0;
      quiet(2);

      // Fetch, zero wait
      @(negedge clk); inst_en = 1; inst_addr = 32'hBFC00000; inst_addr_ok = 1; #2;
      chk("fetch_req0", inst_req, 1);
      chk("fetch_stall0", instrStall, 1);
      chk("fetch_addr0", inst_addr_o, 32'hBFC00000);
      @(negedge clk); inst_addr_ok = 0; inst_data_ok = 1; inst_rdata_i = 32'h3C1D0001; #2;
      chk("fetch_req1", inst_req, 0);
      chk("fetch_stall1", instrStall, 1);
      @(negedge clk); inst_data_ok = 0; #2;
      chk("fetch_stall2", instrStall, 0);
      chk("fetch_rdata2", inst_rdata, 32'h3C1D0001);
      chk("fetch_req2", inst_req, 0);
      quiet(2);

      // Store byte with address back-pressure
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         data_en = 1; data_wen = 4'b0100; data_addr = 32'h80001002; data_wdata = 32'hAABBCCDD;
         data_addr_ok = (i == 3); #2;
         chk("sb_req", data_req, 1);
         chk("sb_wr", data_wr, 1);
         chk("sb_size", data_size, 0);
         chk("sb_addr", data_addr_o, 32'h80001002);
         chk("sb_stall", dataStall, 1);
      end
      @(negedge clk); data_addr_ok = 0; #2;
      chk("sb_req_wait", data_req, 0);
      chk("sb_stall_wait", dataStall, 1);
      @(negedge clk); data_data_ok = 1; data_rdata_i = 0; #2;
      chk("sb_stall_ack", dataStall, 1);
      @(negedge clk); data_data_ok = 0; #2;
      chk("sb_stall_done", dataStall, 0);
      quiet(2);

      // Load held by longest_stall
      @(negedge clk); longest_stall = 1; data_en = 1; data_wen = 0; data_addr = 32'h1000; data_addr_ok = 1;
      @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata_i = 32'hDEADBEEF; #2;
      chk("ls_stall_wait", dataStall, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); data_data_ok = 0; #2;
         chk("ls_rdata_hold", data_rdata, 32'hDEADBEEF);
         chk("ls_no_req", data_req, 0);
      end
      @(negedge clk); longest_stall = 0; #2;
      chk("ls_rdata_last", data_rdata, 32'hDEADBEEF);
      chk("ls_no_req_last", data_req, 0);
      @(negedge clk); data_addr = 32'h2000; #2;
      chk("ls_new_req", data_req, 1);
      quiet(2);

      // Flush while waiting, then re-request at a new address
      @(negedge clk); data_en = 1; data_wen = 0; data_addr = 32'h100; data_addr_ok = 1; #2;
      chk("fl_req0", data_req, 1);
      @(negedge clk); data_en = 0; data_addr_ok = 0; #2;
      chk("fl_req1", data_req, 0);
      chk("fl_stall1", dataStall, 0);
      @(negedge clk); data_en = 1; data_addr = 32'h200; #2;
      chk("fl_req2", data_req, 0);
      chk("fl_stall2", dataStall, 1);
      @(negedge clk); data_data_ok = 1; data_rdata_i = 32'h11111111; #2;
      chk("fl_req3", data_req, 0);
      chk("fl_stall3", dataStall, 1);
      @(negedge clk); data_data_ok = 0; data_addr_ok = 1; #2;
      chk("fl_req4", data_req, 1);
      chk("fl_addr4", data_addr_o, 32'h200);
      @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata_i = 32'h22222222; #2;
      chk("fl_stall5", dataStall, 1);
      @(negedge clk); data_data_ok = 0; #2;
      chk("fl_stall6", dataStall, 0);
      chk("fl_rdata6", data_rdata, 32'h22222222);
      quiet(2);

      // Parallel channels, data response four cycles after the fetch response
      @(negedge clk);
      inst_en = 1; inst_addr = 32'h400; inst_addr_ok = 1;
      data_en = 1; data_wen = 0; data_addr = 32'h500; data_addr_ok = 1; #2;
      chk("par_inst_req", inst_req, 1);
      chk("par_data_req", data_req, 1);
      @(negedge clk); inst_addr_ok = 0; data_addr_ok = 0; inst_data_ok = 1; inst_rdata_i = 32'h12345678; #2;
      chk("par_istall1", instrStall, 1);
      chk("par_dstall1", dataStall, 1);
      @(negedge clk); inst_data_ok = 0; #2;
      chk("par_istall2", instrStall, 0);
      chk("par_irdata2", inst_rdata, 32'h12345678);
      chk("par_dstall2", dataStall, 1);
      @(negedge clk); inst_en = 0;
      @(negedge clk);
      @(negedge clk); data_data_ok = 1; data_rdata_i = 32'h87654321; #2;
      chk("par_dstall5", dataStall, 1);
      @(negedge clk); data_data_ok = 0; #2;
      chk("par_dstall6", dataStall, 0);
      chk("par_drdata6", data_rdata, 32'h87654321);
      quiet(2);

      // Reset while both channels wait
      @(negedge clk);
      data_en = 1; data_wen = 0; data_addr = 32'h600; data_addr_ok = 1;
      inst_en = 1; inst_addr = 32'h700; inst_addr_ok = 1;
      @(negedge clk); data_addr_ok = 0; inst_addr_ok = 0; rst = 1; #2;
      chk("rw_data_req", data_req, 0);
      chk("rw_inst_req", inst_req, 0);
      chk("rw_dstall", dataStall, 1);
      @(negedge clk); rst = 0; data_en = 0; inst_en = 0; #2;
      chk("rw_drdata", data_rdata, 0);
      chk("rw_irdata", inst_rdata, 0);
      chk("rw_dstall_idle", dataStall, 0);
      @(negedge clk); data_en = 1; data_addr = 32'h800; #2;
      chk("rw_new_req", data_req, 1);
      quiet(2);

      // Randomized traffic on both channels
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         longest_stall = ($urandom_range(0, 9) < 4);
         if (!exp_stall(0) || $urandom_range(0, 9) == 0) begin
            inst_en   = ($urandom_range(0, 3) != 0);
            inst_addr = $urandom;
         end
         if (!exp_stall(1) || $urandom_range(0, 9) == 0) begin
            data_en    = ($urandom_range(0, 3) != 0);
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_wen   = wen_tab[$urandom_range(0, 8)];
         end
         inst_addr_ok = ($urandom_range(0, 9) < 4);
         data_addr_ok = ($urandom_range(0, 9) < 4);
         inst_data_ok = m_issued[0] ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
         data_data_ok = m_issued[1] ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
         inst_rdata_i = $urandom;
         data_rdata_i = $urandom;
      end
      rst = 0;
      quiet(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_like_mem_port.md
# sram_like_mem_port

Responder for the core's single-cycle memory-enable interface, one instance per core. It turns the core-side enable/address pair into a split sram-like transaction: `req` held until `addr_ok`, then wait for `data_ok`. The instruction and data channels are independent. It returns `instrStall`/`dataStall` to the core and holds the read data until the whole pipeline releases via `longest_stall`. It sits between the CPU core and the sram-like-to-AXI bridge.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `longest_stall` in 1: core-wide stall. Read data is held while it is high.
- `inst_en` in 1: core fetch enable.
- `inst_addr` in 32: fetch PC.
- `inst_rdata` out 32: fetched word returned to the core.
- `instrStall` out 1: core-side fetch stall.
- `data_en` in 1: core data enable.
- `data_wen` in 4: byte write enables; 0 means read.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data.
- `data_rdata` out 32: load data returned to the core.
- `dataStall` out 1: core-side data stall.
- `inst_req` out 1, `inst_wr` out 1, `inst_size` out 2, `inst_addr_o` out 32, `inst_wdata` out 32: sram-like instruction request.
- `inst_addr_ok` in 1, `inst_data_ok` in 1, `inst_rdata_i` in 32: sram-like instruction response.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_addr_o` out 32, `data_wdata_o` out 32: sram-like data request.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata_i` in 32: sram-like data response.

## Operation
- Each channel has its own FSM with states IDLE, REQ, WAIT, DONE, plus a `cancel` flag. The description below uses the generic names `en`, `req`, `addr_ok`, `data_ok`.
- **IDLE**
  - If `en` is high, `req` is asserted combinationally and the FSM behaves as REQ this cycle.
  - If `addr_ok` is also high, go to WAIT; otherwise go to REQ.
- **REQ**
  - `req` = 1.
  - Address, `wr` and `size` are driven straight from the core inputs; the core holds them stable because it is stalled.
  - On `addr_ok`, go to WAIT.
  - If `en` drops before `addr_ok`, drop `req` and return to IDLE. No transaction has been issued.
- **WAIT**
  - `req` = 0.
  - On `data_ok`:
    - capture `rdata_i` into the hold register;
    - if `en` is high and `cancel` is 0, go to DONE;
    - otherwise go to IDLE and clear `cancel`.
  - If `en` falls while in WAIT (exception flush), set `cancel`. The response is still consumed, because an issued transaction cannot be aborted.
- **DONE**
  - The hold register drives core `rdata`.
  - Return to IDLE in the first cycle `longest_stall` = 0.
- **Stall:** `stall = en & ~(state==DONE)`, plus forced high while `cancel` is set, so a new request waits for the cancelled response to drain.
- **Instruction channel:** `wr` = 0, `size` = 2, `wdata` = 0.
- **Data channel:** `wr = |data_wen`. `size` is decoded from `data_wen`:
  - 4'b1111 → 2;
  - 4'b0011 or 4'b1100 → 1;
  - one-hot → 0;
  - reads → 2 (the core extracts bytes itself).
  - Other `wen` codes → `size` 2 with `wr` = 1. The core never issues them.
- **Writes** also pass through WAIT and DONE; `data_ok` acknowledges the write.
- **Channel independence:** neither channel blocks the other. Both may be in WAIT at the same time.

## Timing
- **Reset values:** all FSMs IDLE, `cancel` = 0.
- **Outputs during reset:**
  - all `req` = 0;
  - `instrStall = inst_en` and `dataStall = data_en` (the combinational stall rule);
  - both hold registers = 0.
- Reset mid-transaction returns to IDLE. The downstream bridge shares `rst`, so no stray `data_ok` follows.
- Minimum latency is `addr_ok` in the request cycle and `data_ok` one cycle later:
  - stall is high for 2 cycles;
  - DONE is entered on the third edge;
  - stall is low in DONE.
- The sram-like rule holds: `data_ok` never arrives in the same cycle as `addr_ok` for the same transaction. `data_ok` seen in IDLE or REQ is ignored.
- The hold register is written only on `data_ok` in WAIT and is stable throughout DONE.
- At most one outstanding transaction per channel.
- If `longest_stall` = 0 on the cycle DONE is entered, DONE lasts exactly 1 cycle.

## Test plan
- **Fetch, zero wait:** `inst_en` = 1, `inst_addr` = 0xBFC00000, `addr_ok` on cycle 0, `data_ok` with 0x3C1D0001 on cycle 1 → `instrStall` = 1,1,0; `inst_rdata` = 0x3C1D0001 in DONE; `inst_req` = 1 only on cycle 0.
- **Store byte, back-pressure:** `data_wen` = 4'b0100, `data_addr` = 0x80001002, `addr_ok` delayed 3 cycles → `data_req` held 4 cycles with `wr` = 1, `size` = 0 and address stable; `dataStall` drops only after `data_ok`.
- **Longest-stall hold:** a load returns 0xDEADBEEF while `longest_stall` stays high 5 more cycles → `data_rdata` = 0xDEADBEEF for all 5 cycles; a new `data_req` appears only after the return to IDLE.
- **Flush in WAIT:** `data_en` drops in WAIT, then reasserts at a new address before `data_ok` → no second request until `data_ok`; old data is discarded; the new request starts the cycle after.
- **Parallel channels:** instruction and data requests issued in the same cycle, with the data response 4 cycles after the instruction response → each stall drops independently and data returns correctly on each channel.
- **Reset in WAIT:** assert `rst` while in WAIT → next cycle IDLE; `req` = 0; hold registers = 0.
